// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state encoding and width helpers for the sequential matrix-multiply engine.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Index/address width for a range of n values; never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Full-precision accumulator: one product plus growth for n accumulated terms plus sign.
    function automatic int acc_w_default(input int data_w, input int n);
        return 2 * data_w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// matmul_mac_unit: signed multiply-accumulate aligned to a 1-cycle synchronous-read memory.
// Latency: operands arrive the cycle after rd_en_i; acc_o reflects them one cycle later.
// Backpressure: none; accumulates whenever a read was issued the previous cycle, otherwise holds.
// Ports: CLK/RST clock and async active-low reset; rd_en_i/first_i read strobe and first-term flag
//        of the issuing cycle; a_i/b_i memory read data; acc_o running sum modulo 2^ACC_W.
module matmul_mac_unit
    import matmul_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = acc_w_default(DATA_W, 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     rd_en_i,
    input  logic                     first_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic                    rd_valid_q;
    logic                    first_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] prod;

    // Sign-extending both operands to ACC_W before multiplying yields the exact product
    // modulo 2^ACC_W, which is all the wrapping accumulator ever needs.
    assign prod = ACC_W'(a_i) * ACC_W'(b_i);

    // The first term of a dot product overwrites the accumulator instead of adding,
    // so no separate clear cycle is needed between C elements.
    always_comb begin
        acc_d = acc_q;
        if (rd_valid_q) begin
            acc_d = first_q ? prod : acc_q + prod;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_valid_q <= 1'b0;
            first_q    <= 1'b0;
            acc_q      <= '0;
        end else begin
            rd_valid_q <= rd_en_i;
            first_q    <= rd_en_i && first_i;
            acc_q      <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matmul_seq_fsmd.sv
// matmul_seq_fsmd: sequential C[MxP] = A[MxN] * B[NxP], one signed MAC per cycle, loop order i, j, k.
// Latency: N+2 cycles per C element with out_ready high; done pulses M*P*(N+2)+1 cycles after start.
// Backpressure: EMIT holds out_valid/out_data/out_row/out_col stable and issues no reads while out_ready is low.
// Ports: CLK/RST clock and async active-low reset; start/busy/done control handshake;
//        rd_en/a_addr/b_addr/a_data/b_data drive synchronous-read A and B memories (1-cycle latency);
//        out_valid/out_ready/out_data/out_row/out_col stream C elements in row-major order.
module matmul_seq_fsmd
    import matmul_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  M      = 3,
    parameter int  N      = 3,
    parameter int  P      = 3,
    parameter int  ACC_W  = acc_w_default(DATA_W, N),
    localparam int AW     = idx_w(M * N),
    localparam int BW     = idx_w(N * P),
    localparam int RW     = idx_w(M),
    localparam int CW     = idx_w(P)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [AW-1:0]            a_addr,
    output logic [BW-1:0]            b_addr,
    input  logic signed [DATA_W-1:0] a_data,
    input  logic signed [DATA_W-1:0] b_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [RW-1:0]            out_row,
    output logic [CW-1:0]            out_col
);

    localparam int            KW     = idx_w(N);
    localparam logic [RW-1:0] I_LAST = RW'(M - 1);
    localparam logic [CW-1:0] J_LAST = CW'(P - 1);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t                  state_q, state_d;
    logic [RW-1:0]           i_q, i_d;
    logic [CW-1:0]           j_q, j_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    first;
    logic signed [ACC_W-1:0] acc;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        busy      = 1'b1;
        done      = 1'b0;
        rd_en     = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                rd_en = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            // Last read's data is on a_data/b_data now; the MAC folds it in at this edge.
            DRAIN: begin
                state_d = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (j_q == J_LAST) begin
                        j_d = '0;
                        i_d = (i_q == I_LAST) ? '0 : i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                    state_d = (i_q == I_LAST && j_q == J_LAST) ? DONE : RUN;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Addresses are only meaningful while reading; park them at zero otherwise.
    assign a_addr = rd_en ? AW'(int'(i_q) * N + int'(k_q)) : '0;
    assign b_addr = rd_en ? BW'(int'(k_q) * P + int'(j_q)) : '0;
    assign first  = rd_en && (k_q == '0);

    matmul_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .CLK     (CLK),
        .RST     (RST),
        .rd_en_i (rd_en),
        .first_i (first),
        .a_i     (a_data),
        .b_i     (b_data),
        .acc_o   (acc)
    );

    assign out_data = out_valid ? acc : '0;
    assign out_row  = i_q;
    assign out_col  = j_q;

endmodule

// File: doc/matmul_seq_fsmd.md
Name: matmul_seq_fsmd

Overview:
Parametrised sequential matrix-multiply engine computing C[M x P] = A[M x N] * B[N x P].
- Controller and datapath are merged in one block; loop order is i (row) outer, j (column) middle, k (inner) innermost.
- Addresses A and B in external synchronous-read memories (1-cycle read latency) and runs one signed MAC per cycle.
- Streams each finished C element on a valid/ready port, then reports completion.
- Generalises the fixed 3x3 loop-nest controller: arbitrary dimensions, start/done handshake, output back-pressure.

Parameters:
DATA_W, 8, signed width of A and B elements
M, 3, rows of A and C
N, 3, inner dimension (columns of A, rows of B); must be >= 1
P, 3, columns of B and C
ACC_W, 2*DATA_W+$clog2(N)+1, accumulator and result width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
start  in  1  begin a multiplication; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last C element is accepted
rd_en  out  1  read strobe for the A and B memories
a_addr  out  clog2(M*N)  A address = i*N + k
b_addr  out  clog2(N*P)  B address = k*P + j
a_data  in  DATA_W  A element, valid the cycle after rd_en
b_data  in  DATA_W  B element, valid the cycle after rd_en
out_valid  out  1  C element available
out_ready  in  1  consumer accepts when out_valid && out_ready
out_data  out  ACC_W  C[i][j]
out_row  out  clog2(M)  i of the presented element
out_col  out  clog2(P)  j of the presented element

Behaviour:
- Reset (async, RST=0):
  - state=IDLE; i=j=k=0; acc=0; rd_valid_q=0.
  - All outputs 0: busy, done, rd_en, out_valid, out_data, addresses.
  - Reset mid-operation abandons the computation; no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, EMIT, DONE.
- IDLE:
  - start=1 clears i, j, k and moves to RUN next cycle.
  - start=0 holds IDLE.
  - start in any other state is ignored.
- RUN:
  - rd_en=1; addresses are driven combinationally from i, j, k.
  - k increments each cycle.
  - When k==N-1, k wraps to 0 and the next state is DRAIN.
  - RUN therefore lasts exactly N cycles per element.
- Datapath pipeline:
  - rd_valid_q <= rd_en; first_q <= (rd_en && k==0).
  - On rd_valid_q: acc <= first_q ? a*b : acc + a*b.
  - Multiplication is signed, sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W.
- DRAIN:
  - rd_en=0; the last product accumulates this cycle.
  - Next state is EMIT.
- EMIT:
  - out_valid=1; out_data=acc; out_row=i; out_col=j.
  - All three outputs stay stable while out_ready=0 (back-pressure); acc is not modified.
  - On acceptance, j increments. At j==P-1, j wraps to 0 and i increments.
  - If the accepted element is (M-1, P-1), next state is DONE; otherwise RUN.
- DONE: done=1 and busy=1 for one cycle, then IDLE. A start seen in DONE is ignored.
- Latency with start sampled at edge 0 and out_ready held at 1:
  - First out_valid in cycle N+2.
  - Each element takes N+2 cycles.
  - done is asserted in cycle M*P*(N+2)+1.
- N==1: RUN lasts one cycle and first_q is always 1.
- rd_en is never high outside RUN; out_valid is never high outside EMIT.

Decomposition:
- Shared package matmul_pkg holds:
  - state enum: IDLE=0, RUN=1, DRAIN=2, EMIT=3, DONE=4 (3-bit);
  - index-width localparam functions based on clog2;
  - default ACC_W formula.
- One sub-module, matmul_mac_unit (DATA_W, ACC_W), holds the signed multiply, the accumulator register, and first/valid qualification.
- The FSM and loop counters stay in the top level.

Test Plan:
1. M=N=P=3; A=identity, B=[1..9] row-major; out_ready=1 → outputs 1..9 in row-major order with (row,col) = (0,0)..(2,2); done in cycle 46.
2. M=2, N=3, P=2; A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]] → out_data sequence 58, 64, 139, 154; address trace for element (0,0) is a_addr=0,1,2 and b_addr=0,2,4.
3. DATA_W=8; A row all -128, B column all -128, N=3 → out_data=49152. Same test with ACC_W forced to 16 → wraps to 49152 mod 65536 interpreted signed = -16384.
4. Back-pressure: out_ready held 0 for 5 cycles at first EMIT → out_valid/out_data/out_row/out_col stable; rd_en=0 throughout; results unchanged afterwards.
5. Pulse start while busy in RUN and again in DONE → ignored; exactly one done pulse; result count = M*P.
6. Assert RST low during RUN of element (1,1) → all outputs 0 immediately; new start gives correct full result set; no stale accumulation.
